// File: rtl/handshake_pkg.sv
// Shared types and constants for the handshake transmit queue.
// The FSM encoding and counter widths live here so the top and bench agree on them.
package handshake_pkg;

    localparam int SENT_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_t;

    // Width of a down-to-zero style counter that must hold values 0..limit-1.
    function automatic int cnt_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/handshake_tx_queue_sync_fifo.sv
// Small synchronous FIFO with a show-ahead head word.
// full/empty/level decode the registered occupancy; a push while full is ignored.
module sync_fifo #(
    parameter int N     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk1,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [N-1:0]             wr_data,
    input  logic                     rd_en,
    output logic [N-1:0]             rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [N-1:0]    mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            push, pop;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rd_data = mem_q[rd_ptr_q];

    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        push     = wr_en && !full;
        pop      = rd_en && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together from pre-edge values.
    always_ff @(posedge clk1 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: storage is not reset; emptiness is tracked by level, so stale words are never presented as valid.
    always_ff @(posedge clk1) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/handshake_tx_queue.sv
// Queue in front of the four-phase handshake transmitter: buffers producer words and
// issues one per completed busy1 high->low cycle, flagging drops and unacknowledged words.
module handshake_tx_queue
    import handshake_pkg::*;
#(
    parameter int N           = 8,
    parameter int DEPTH       = 4,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                     clk1,
    input  logic                     reset_n,
    input  logic [N-1:0]             wr_data,
    input  logic                     wr_en,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [N-1:0]             data1,
    output logic                     newdata1,
    input  logic                     busy1,
    output logic [SENT_CNT_W-1:0]    sent_cnt,
    output logic                     overflow,
    output logic                     timeout
);

    localparam int TW = cnt_width(ACK_TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);

    tx_state_t               state_q, state_d;
    logic [N-1:0]            data1_q, data1_d;
    logic                    newdata1_q, newdata1_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic [SENT_CNT_W-1:0]   sent_cnt_q, sent_cnt_d;
    logic                    overflow_q, overflow_d;
    logic                    timeout_q, timeout_d;

    logic                    pop;
    logic [N-1:0]            head;
    logic                    fifo_full, fifo_empty;

    sync_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk1    (clk1),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    assign full     = fifo_full;
    assign empty    = fifo_empty;
    assign data1    = data1_q;
    assign newdata1 = newdata1_q;
    assign sent_cnt = sent_cnt_q;
    assign overflow = overflow_q;
    assign timeout  = timeout_q;

    always_ff @(posedge clk1 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            data1_q    <= '0;
            newdata1_q <= 1'b0;
            timer_q    <= '0;
            sent_cnt_q <= '0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            data1_q    <= data1_d;
            newdata1_q <= newdata1_d;
            timer_q    <= timer_d;
            sent_cnt_q <= sent_cnt_d;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
        end
    end

    // A busy1 already high in IDLE belongs to someone else's transfer; wait it out.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (!fifo_empty && !busy1) state_d = SEND;
            SEND:      state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                if (busy1) begin
                    state_d = WAIT_DONE;
                end else if (timer_q == TIMER_LAST) begin
                    state_d = IDLE;
                end
            end
            WAIT_DONE: if (!busy1) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        pop        = 1'b0;
        data1_d    = data1_q;
        newdata1_d = 1'b0;
        timer_d    = timer_q;
        sent_cnt_d = sent_cnt_q;
        timeout_d  = timeout_q;
        // full is the pre-edge value, so a push on the pop cycle of a full queue is still dropped.
        overflow_d = overflow_q | (wr_en & fifo_full);
        case (state_q)
            IDLE: begin
                if (!fifo_empty && !busy1) begin
                    pop        = 1'b1;
                    data1_d    = head;
                    newdata1_d = 1'b1;
                end
            end
            SEND: begin
                timer_d = '0;
            end
            WAIT_BUSY: begin
                if (!busy1) begin
                    timer_d = timer_q + TW'(1);
                    if (timer_q == TIMER_LAST) begin
                        timeout_d = 1'b1;
                    end
                end
            end
            WAIT_DONE: begin
                if (!busy1) begin
                    sent_cnt_d = sent_cnt_q + SENT_CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_handshake_tx_queue.sv
// Self-checking bench for handshake_tx_queue: a negedge monitor keeps a word-queue model,
// plays the handshake (busy1) side, and compares every output each cycle.
module tb_handshake_tx_queue;

    localparam int N           = 8;
    localparam int DEPTH       = 4;
    localparam int ACK_TIMEOUT = 16;
    localparam int LW          = $clog2(DEPTH) + 1;
    // newdata1 seen at negedge n0 -> SEND, then ACK_TIMEOUT edges in WAIT_BUSY.
    localparam int TO_LAT      = ACK_TIMEOUT + 1;

    logic            clk1 = 1'b0;
    logic            reset_n;
    logic [N-1:0]    wr_data;
    logic            wr_en;
    logic            full, empty;
    logic [LW-1:0]   level;
    logic [N-1:0]    data1;
    logic            newdata1;
    logic            busy1;
    logic [15:0]     sent_cnt;
    logic            overflow, timeout;

    int tests_run    = 0;
    int tests_failed = 0;

    handshake_tx_queue #(.N(N), .DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk1     (clk1),
        .reset_n  (reset_n),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .data1    (data1),
        .newdata1 (newdata1),
        .busy1    (busy1),
        .sent_cnt (sent_cnt),
        .overflow (overflow),
        .timeout  (timeout)
    );

    always #5 clk1 = ~clk1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model + handshake responder ----------------
    logic [N-1:0]   model_q[$];
    logic [N-1:0]   exp_data1;
    logic [15:0]    exp_sent;
    bit             exp_ovf, exp_to, ovf_pend, sent_pend, pend_acc;
    logic [N-1:0]   pend_data;
    int             hs_phase, hs_cnt, hs_len, to_cnt, pulses;
    bit             busy_drv, prev_busy, prev_nd, seen_ff;
    bit             hs_hold  = 1'b0;   // foreign transfer: busy1 forced high
    bit             hs_noack = 1'b0;   // next issued word never acknowledged

    initial begin
        busy1     = 1'b0;
        exp_data1 = '0;
        exp_sent  = '0;
        to_cnt    = -1;
        pulses    = 0;
        seen_ff   = 1'b0;
        forever begin
            @(negedge clk1);
            if (!reset_n) begin
                model_q.delete();
                exp_data1 = '0;  exp_sent = '0;
                exp_ovf = 0; exp_to = 0; ovf_pend = 0; sent_pend = 0; pend_acc = 0;
                hs_phase = 0; hs_cnt = 0; to_cnt = -1; busy_drv = 0;
                check("rst_newdata1", newdata1, 0);
                check("rst_data1", data1, 0);
                check("rst_sent_cnt", sent_cnt, 0);
                check("rst_overflow", overflow, 0);
                check("rst_timeout", timeout, 0);
                check("rst_full", full, 0);
                check("rst_empty", empty, 1);
                check("rst_level", level, 0);
                busy1 = 1'b0;
                prev_busy = 1'b0;
                prev_nd = 1'b0;
            end else begin
                if (sent_pend) begin exp_sent = exp_sent + 16'd1; sent_pend = 0; end
                if (ovf_pend) begin exp_ovf = 1; ovf_pend = 0; end
                if (to_cnt >= 0) begin
                    to_cnt++;
                    if (to_cnt == TO_LAT) begin exp_to = 1; to_cnt = -1; end
                end
                if (hs_phase == 1) begin
                    hs_cnt++;
                    if (hs_cnt == 2) begin busy_drv = 1; hs_phase = 2; hs_cnt = 0; end
                end else if (hs_phase == 2) begin
                    hs_cnt++;
                    if (hs_cnt == hs_len) begin busy_drv = 0; hs_phase = 0; sent_pend = 1; end
                end
                if (newdata1) begin
                    pulses++;
                    check("pulse_one_cycle", prev_nd, 0);
                    check("pulse_busy_low", prev_busy, 0);
                    if (data1 == 8'hFF) seen_ff = 1'b1;
                    if (model_q.size() == 0) check("pulse_spurious", newdata1, 0);
                    else exp_data1 = model_q.pop_front();
                    if (hs_noack) begin
                        to_cnt = 0;
                    end else begin
                        hs_phase = 1; hs_cnt = 0; hs_len = $urandom_range(20, 3);
                    end
                end
                if (pend_acc) model_q.push_back(pend_data);
                pend_acc = 0;
                check("data1", data1, exp_data1);
                check("level", level, model_q.size());
                check("full", full, model_q.size() == DEPTH);
                check("empty", empty, model_q.size() == 0);
                check("sent_cnt", sent_cnt, exp_sent);
                check("overflow", overflow, exp_ovf);
                check("timeout", timeout, exp_to);
                // wr_en is sampled by the next posedge; full is judged on pre-pop occupancy
                if (wr_en) begin
                    if (model_q.size() < DEPTH) begin pend_acc = 1; pend_data = wr_data; end
                    else ovf_pend = 1;
                end
                busy1 = hs_hold | busy_drv;
                prev_busy = busy1;
                prev_nd = newdata1;
            end
        end
    end

    // ---------------- stimulus helpers (all start/end at posedge+1) ----------------
    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic push(input logic [N-1:0] d);
        wr_en = 1'b1;
        wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    function automatic bit model_idle();
        return model_q.size() == 0 && hs_phase == 0 && to_cnt < 0 && !sent_pend &&
               !pend_acc && !ovf_pend && !newdata1;
    endfunction

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (!model_idle() && n < budget) begin
            step();
            n++;
        end
        repeat (2) step();
        check(tag, (n < budget), 1);
    endtask

    logic [15:0] base;
    int          p0, n;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        repeat (3) step();
        reset_n = 1'b1;
        step();

        // 1: reset in the middle of a transfer abandons the word, no pulse afterwards
        push(8'h3C);
        n = 0;
        while (!busy1 && n < 20) begin step(); n++; end
        check("t1_busy_seen", busy1, 1);
        step();
        reset_n = 1'b0;
        step();
        check("t1_in_rst_newdata1", newdata1, 0);
        check("t1_in_rst_level", level, 0);
        step();
        reset_n = 1'b1;
        p0 = pulses;
        repeat (8) step();
        check("t1_no_pulse", pulses, p0);
        check("t1_data1", data1, 0);
        check("t1_sent", sent_cnt, 0);

        // 2: wr_en launched after edge P; sampled at P+1, newdata1 driven at P+2
        wr_en = 1'b1;
        wr_data = 8'hA5;
        step();
        wr_en = 1'b0;
        check("t2_no_pulse_yet", newdata1, 0);
        step();
        check("t2_pulse", newdata1, 1);
        check("t2_data1", data1, 8'hA5);
        wait_idle("t2_drain", 100);
        check("t2_sent", sent_cnt, 1);

        // 3: burst of four while a foreign transfer holds busy1, then drain in order
        hs_hold = 1'b1;
        repeat (2) step();
        p0 = pulses;
        for (int i = 1; i <= 4; i++) begin
            wr_en = 1'b1;
            wr_data = N'(i);
            step();
        end
        wr_en = 1'b0;
        check("t3_full", full, 1);
        check("t3_level", level, 4);
        hs_hold = 1'b0;
        wait_idle("t3_drain", 300);
        check("t3_pulses", pulses - p0, 4);
        check("t3_sent", sent_cnt, 5);
        check("t3_empty", empty, 1);

        // 4: overflow: fifth word dropped, never transmitted
        hs_hold = 1'b1;
        repeat (2) step();
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1;
            wr_data = (i == 4) ? 8'hFF : N'(8'h40 + i);
            step();
        end
        wr_en = 1'b0;
        check("t4_overflow", overflow, 1);
        check("t4_level", level, 4);
        hs_hold = 1'b0;
        wait_idle("t4_drain", 300);
        check("t4_sent", sent_cnt, 9);
        check("t4_ff_never_sent", seen_ff, 0);

        // 5: handshake never answers -> timeout; the next word goes through normally
        base = sent_cnt;
        hs_noack = 1'b1;
        push(8'h5A);
        wait_idle("t5_timeout_wait", 100);
        hs_noack = 1'b0;
        check("t5_timeout", timeout, 1);
        check("t5_sent_unchanged", sent_cnt, base);
        push(8'h6B);
        wait_idle("t5_drain", 100);
        check("t5_sent_after", sent_cnt, 16'(base + 16'd1));

        // 6: push on the pop cycle at level 1, then sent_cnt wrap
        base = sent_cnt;
        hs_hold = 1'b1;
        repeat (2) step();
        push(8'h11);
        check("t6_level_pre", level, 1);
        hs_hold = 1'b0;
        wr_en = 1'b1;
        wr_data = 8'h22;
        step();
        wr_en = 1'b0;
        check("t6_pulse", newdata1, 1);
        check("t6_data1", data1, 8'h11);
        check("t6_level_same", level, 1);
        wait_idle("t6_drain", 200);
        check("t6_sent", sent_cnt, 16'(base + 16'd2));
        force dut.sent_cnt_q = 16'hFFFF;
        exp_sent = 16'hFFFF;
        step();
        release dut.sent_cnt_q;
        push(8'h33);
        wait_idle("t6_wrap_drain", 100);
        check("t6_wrap", sent_cnt, 0);

        // randomized traffic: bursty pushes, random ack lengths, occasional no-ack and foreign busy
        for (int c = 0; c < 1500; c++) begin
            wr_en = ($urandom_range(3, 0) == 0);
            wr_data = N'($urandom);
            hs_noack = ($urandom_range(15, 0) == 0);
            if (!hs_hold && (c % 200) > 100 && (c % 200) < 110 && model_idle() && !wr_en)
                hs_hold = 1'b1;
            else if (hs_hold && (c % 200) >= 140)
                hs_hold = 1'b0;
            step();
        end
        wr_en = 1'b0;
        hs_noack = 1'b0;
        hs_hold = 1'b0;
        wait_idle("rand_drain", 800);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
